mux_4_1_arbiter: RTL and testbench

MUX_4_1_ARBITER -- requirements
Module: mux_4_1_arbiter

---
 rtl/mux_4_1_arbiter.sv | 95 +++++++++
 tb/tb_mux_4_1_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_arbiter.sv
// Round-robin arbiter driving a registered 4:1 mux select.
// The owner keeps the grant for up to MAX_HOLD consecutive cycles.
module mux_4_1_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       y,
  output logic       busy,
  output logic       state_dbg,
  output logic [3:0] cnt_dbg,
  output logic [1:0] ptr_dbg
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [0:0] state;
  logic [3:0] cnt;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic [1:0] rel_ptr;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;
  logic       keep;

  // Returns {found, index} of the first requester at or after p, wrapping mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    rel_ptr   = sel + 2'd1;
    pick_idle = pick(req, ptr);
    pick_rel  = pick(req, rel_ptr);
    keep      = req[sel] && (cnt < HOLD_MAX);
  end

  // In GRANT, sel is the owner; on release the search restarts just past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      ptr   <= 2'd0;
    end else if (state == IDLE) begin
      if (pick_idle[2]) begin
        state <= GRANT;
        sel   <= pick_idle[1:0];
        gnt   <= 4'b0001 << pick_idle[1:0];
        busy  <= 1'b1;
        cnt   <= 4'd1;
      end
    end else begin
      if (keep) begin
        cnt <= cnt + 4'd1;
      end else begin
        ptr <= rel_ptr;
        if (pick_rel[2]) begin
          sel <= pick_rel[1:0];
          gnt <= 4'b0001 << pick_rel[1:0];
          cnt <= 4'd1;
        end else begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          cnt   <= 4'd0;
        end
      end
    end
  end

  assign s1        = sel[1];
  assign s0        = sel[0];
  assign y         = din[sel];
  assign state_dbg = state;
  assign cnt_dbg   = cnt;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Bench for mux_4_1_arbiter: three instances (MAX_HOLD 8, 4, 1) share stimulus
// and are compared each cycle against a rule-level round-robin model.
module tb_mux_4_1_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;

  logic [3:0] gnt_o   [3];
  logic       s1_o    [3];
  logic       s0_o    [3];
  logic       y_o     [3];
  logic       busy_o  [3];
  logic       state_o [3];
  logic [3:0] cnt_o   [3];
  logic [1:0] ptr_o   [3];

  mux_4_1_arbiter #(.MAX_HOLD(8)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_o[0]), .s1(s1_o[0]),
    .s0(s0_o[0]), .y(y_o[0]), .busy(busy_o[0]), .state_dbg(state_o[0]),
    .cnt_dbg(cnt_o[0]), .ptr_dbg(ptr_o[0]));
  mux_4_1_arbiter #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_o[1]), .s1(s1_o[1]),
    .s0(s0_o[1]), .y(y_o[1]), .busy(busy_o[1]), .state_dbg(state_o[1]),
    .cnt_dbg(cnt_o[1]), .ptr_dbg(ptr_o[1]));
  mux_4_1_arbiter #(.MAX_HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt_o[2]), .s1(s1_o[2]),
    .s0(s0_o[2]), .y(y_o[2]), .busy(busy_o[2]), .state_dbg(state_o[2]),
    .cnt_dbg(cnt_o[2]), .ptr_dbg(ptr_o[2]));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner index (-1 = none), hold count, pointer, last select
  int hold    [3] = '{8, 4, 1};
  int m_owner [3];
  int m_cnt   [3];
  int m_ptr   [3];
  int m_sel   [3];

  logic [41:0] exp_q[$];
  logic [41:0] exp_v;
  wire  [41:0] obs_all;
  wire  [2:0]  y_all;

  function automatic logic [13:0] obs_one(int u);
    return {state_o[u], cnt_o[u], ptr_o[u], gnt_o[u], s1_o[u], s0_o[u], busy_o[u]};
  endfunction

  assign obs_all = {obs_one(0), obs_one(1), obs_one(2)};
  assign y_all   = {y_o[0], y_o[1], y_o[2]};

  function automatic int first_req(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_owner[u] = -1; m_cnt[u] = 0; m_ptr[u] = 0; m_sel[u] = 0;
    end
  endtask

  task automatic model_step(logic [3:0] r);
    int w;
    for (int u = 0; u < 3; u++) begin
      if (m_owner[u] < 0) begin
        w = first_req(r, m_ptr[u]);
        if (w >= 0) begin m_owner[u] = w; m_cnt[u] = 1; m_sel[u] = w; end
      end else if (r[m_owner[u]] && m_cnt[u] < hold[u]) begin
        m_cnt[u] = m_cnt[u] + 1;
      end else begin
        m_ptr[u] = (m_owner[u] + 1) % 4;
        w = first_req(r, m_ptr[u]);
        if (w >= 0) begin m_owner[u] = w; m_cnt[u] = 1; m_sel[u] = w; end
        else begin m_owner[u] = -1; m_cnt[u] = 0; end
      end
    end
  endtask

  function automatic logic [13:0] model_one(int u);
    logic [3:0] g;
    g = (m_owner[u] >= 0) ? 4'(1 << m_owner[u]) : 4'b0000;
    return {(m_owner[u] >= 0), 4'(m_cnt[u]), 2'(m_ptr[u]), g, 2'(m_sel[u]),
            (m_owner[u] >= 0)};
  endfunction

  function automatic logic [41:0] model_all();
    return {model_one(0), model_one(1), model_one(2)};
  endfunction

  function automatic logic [2:0] model_y();
    return {din[m_sel[0]], din[m_sel[1]], din[m_sel[2]]};
  endfunction

  // driver: one rising edge, model advanced on it, outputs sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(req);
    exp_q.push_back(model_all());
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    din = 4'(($urandom_range(0, 7) << 1) | 1);
    model_reset();
    #1;
    exp_v = model_all();
    vectors++;
    if (obs_all !== exp_v) begin
      miscompares++; $display("FAIL reset_state: got %h want %h", obs_all, exp_v);
    end
    vectors++;
    if (y_all !== 3'b111) begin
      miscompares++; $display("FAIL reset_y: got %b want 111", y_all);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL reset_hold: got %h want %h", obs_all, exp_v);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_hold_limit();
    apply_reset();
    req = 4'b0101;
    for (int e = 1; e <= 10; e++) begin
      din = 4'($urandom_range(0, 15));
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL hold_limit e%0d: got %h want %h", e, obs_all, exp_v);
      end
      vectors++;
      if (y_all !== model_y()) begin
        miscompares++; $display("FAIL hold_limit_y e%0d: got %b want %b", e, y_all, model_y());
      end
      if (e == 1 || e == 8 || e == 9) begin
        vectors++;
        if (gnt_o[0] !== ((e == 9) ? 4'b0100 : 4'b0001)) begin
          miscompares++;
          $display("FAIL hold_limit_gnt8 e%0d: got %b want %b", e, gnt_o[0],
                   (e == 9) ? 4'b0100 : 4'b0001);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      din = 4'($urandom_range(0, 15));
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL round_robin e%0d: got %h want %h", e, obs_all, exp_v);
      end
      vectors++;
      if (gnt_o[2] !== seq[e] || {s1_o[2], s0_o[2]} !== 2'(e % 4) || y_o[2] !== din[e % 4]) begin
        miscompares++;
        $display("FAIL round_robin_gnt1 e%0d: got gnt %b sel %0d y %b want gnt %b sel %0d y %b",
                 e, gnt_o[2], {s1_o[2], s0_o[2]}, y_o[2], seq[e], e % 4, din[e % 4]);
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    for (int e = 1; e <= 4; e++) begin
      req = (e == 1) ? 4'b0100 : (e == 4) ? 4'b0001 : 4'b0101;
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL early_release e%0d: got %h want %h", e, obs_all, exp_v);
      end
      vectors++;
      if (busy_o[0] !== 1'b1 || gnt_o[0] !== ((e == 4) ? 4'b0001 : 4'b0100)) begin
        miscompares++;
        $display("FAIL early_release_gnt8 e%0d: got gnt %b busy %b want gnt %b busy 1",
                 e, gnt_o[0], busy_o[0], (e == 4) ? 4'b0001 : 4'b0100);
      end
    end
  endtask

  task automatic test_solo();
    apply_reset();
    req = 4'b0010;
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL solo e%0d: got %h want %h", e, obs_all, exp_v);
      end
      vectors++;
      if (gnt_o[1] !== 4'b0010 || busy_o[1] !== 1'b1 || cnt_o[1] !== 4'((e % 4) + 1)) begin
        miscompares++;
        $display("FAIL solo_gnt4 e%0d: got gnt %b busy %b cnt %0d want gnt 0010 busy 1 cnt %0d",
                 e, gnt_o[1], busy_o[1], cnt_o[1], (e % 4) + 1);
      end
    end
  endtask

  task automatic test_idle_return();
    apply_reset();
    for (int e = 0; e < 5; e++) begin
      req = (e < 2) ? 4'b1000 : 4'b0000;
      din = 4'($urandom_range(0, 15));
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL idle_return e%0d: got %h want %h", e, obs_all, exp_v);
      end
      if (e >= 2) begin
        vectors++;
        if (gnt_o[0] !== 4'b0000 || busy_o[0] !== 1'b0 || {s1_o[0], s0_o[0]} !== 2'b11 ||
            y_o[0] !== din[3]) begin
          miscompares++;
          $display("FAIL idle_return_8 e%0d: got gnt %b busy %b sel %b y %b want 0000 0 11 %b",
                   e, gnt_o[0], busy_o[0], {s1_o[0], s0_o[0]}, y_o[0], din[3]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0100;
    tick();
    tick();
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_v = model_all();
    vectors++;
    if (obs_all !== exp_v || gnt_o[0] !== 4'b0000 || busy_o[0] !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got %h want %h", obs_all, exp_v);
    end
    vectors++;
    if (y_all !== {3{din[0]}}) begin
      miscompares++; $display("FAIL async_reset_y: got %b want %b", y_all, {3{din[0]}});
    end
    rst_n = 1'b1;
    req = 4'b1000;
    tick();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_all !== exp_v || gnt_o[0] !== 4'b1000) begin
      miscompares++; $display("FAIL async_reset_regrant: got %h want %h", obs_all, exp_v);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int e = 0; e < 400; e++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      din = 4'($urandom_range(0, 15));
      tick();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_all !== exp_v) begin
        miscompares++; $display("FAIL random e%0d: got %h want %h", e, obs_all, exp_v);
      end
      vectors++;
      if (y_all !== model_y()) begin
        miscompares++; $display("FAIL random_y e%0d: got %b want %b", e, y_all, model_y());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_limit();
    test_round_robin();
    test_early_release();
    test_solo();
    test_idle_return();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
